// File: rtl/dma_controller.sv
// Bus-master DMA engine: acquires the memory bus via br/bg, reads LINES device lines
// by offset and writes each one to memory as a single line-write, then pulses dma_end.
module dma_controller #(
    parameter int WORD_SIZE      = 16,
    parameter int LINE_WORDS     = 4,
    parameter int LINES          = 3,
    parameter int DEVICE_BIT_LEN = 2
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             cmd,
    input  logic [WORD_SIZE-1:0]             cmd_addr,
    output logic                             br,
    input  logic                             bg,
    output logic [DEVICE_BIT_LEN-1:0]        offset,
    input  logic [LINE_WORDS*WORD_SIZE-1:0]  dev_data,
    output logic                             mem_write,
    output logic [WORD_SIZE-1:0]             mem_addr,
    output logic [LINE_WORDS*WORD_SIZE-1:0]  mem_data,
    input  logic                             mem_ack,
    output logic                             dma_end,
    output logic                             busy
);
    localparam int DW = LINE_WORDS * WORD_SIZE;

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_SETUP, S_WRITE, S_RELEASE
    } state_t;

    state_t                    r_state;
    logic [WORD_SIZE-1:0]      r_base;
    logic [DEVICE_BIT_LEN-1:0] r_idx;
    logic                      r_br;
    logic [DEVICE_BIT_LEN-1:0] r_offset;
    logic                      r_mem_write;
    logic [WORD_SIZE-1:0]      r_mem_addr;
    logic [DW-1:0]             r_mem_data;
    logic                      r_dma_end;
    logic                      r_busy;

    logic [WORD_SIZE-1:0]      w_line_addr;
    logic [DEVICE_BIT_LEN-1:0] w_idx_nxt;
    logic                      w_last;

    // Line address wraps naturally at 2^WORD_SIZE.
    assign w_line_addr = r_base + (WORD_SIZE'(r_idx) * WORD_SIZE'(LINE_WORDS));
    assign w_idx_nxt   = r_idx + 1'b1;
    assign w_last      = (r_idx == DEVICE_BIT_LEN'(LINES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_idx       <= '0;
            r_br        <= 1'b0;
            r_offset    <= '1;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_dma_end   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_dma_end <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd) begin
                        r_base  <= cmd_addr;
                        r_idx   <= '0;
                        r_br    <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bg) begin
                        r_offset <= r_idx;
                        r_state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (!bg) begin
                        r_offset <= '1;
                        r_state  <= S_REQ;
                    end else begin
                        r_mem_data  <= dev_data;
                        r_mem_addr  <= w_line_addr;
                        r_mem_write <= 1'b1;
                        r_state     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    // An ack in the same cycle as grant loss still completes the line.
                    if (mem_ack) begin
                        r_mem_write <= 1'b0;
                        if (w_last) begin
                            r_br     <= 1'b0;
                            r_offset <= '1;
                            r_state  <= S_RELEASE;
                        end else begin
                            r_idx    <= w_idx_nxt;
                            r_offset <= bg ? w_idx_nxt : '1;
                            r_state  <= bg ? S_SETUP : S_REQ;
                        end
                    end else if (!bg) begin
                        r_mem_write <= 1'b0;
                        r_offset    <= '1;
                        r_state     <= S_REQ;
                    end
                end
                S_RELEASE: begin
                    if (!bg) begin
                        r_busy    <= 1'b0;
                        r_dma_end <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign br        = r_br;
    assign offset    = r_offset;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_data  = r_mem_data;
    assign dma_end   = r_dma_end;
    assign busy      = r_busy;
endmodule

// File: tb/tb_dma_controller.sv
// Directed bench for dma_controller: device lines are fixed patterns per offset,
// memory acks one cycle after a write appears, CPU grant is driven per scenario.
module tb_dma_controller;
    localparam logic [63:0] L0 = 64'h1003_1002_1001_1000;
    localparam logic [63:0] L1 = 64'h2003_2002_2001_2000;
    localparam logic [63:0] L2 = 64'h3003_3002_3001_3000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd;
    logic [15:0] cmd_addr;
    logic        br;
    logic        bg;
    logic [1:0]  offset;
    logic [63:0] dev_data;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [63:0] mem_data;
    logic        mem_ack = 1'b0;
    logic        dma_end;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [15:0] log_addr[$];
    logic [63:0] log_data[$];
    int          end_pulses = 0;
    int          end_hi     = 0;
    logic        end_prev   = 1'b0;
    logic        hold_ack   = 1'b0;
    logic [15:0] hold_addr  = 16'h0;
    logic [63:0] lpat [3];

    dma_controller dut (
        .clk(clk), .reset_n(reset_n), .cmd(cmd), .cmd_addr(cmd_addr),
        .br(br), .bg(bg), .offset(offset), .dev_data(dev_data),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_ack(mem_ack), .dma_end(dma_end), .busy(busy)
    );

    always #5 clk = ~clk;

    assign dev_data = (offset == 2'd0) ? L0 :
                      (offset == 2'd1) ? L1 :
                      (offset == 2'd2) ? L2 : 64'h0;

    // Memory responder and completion monitor; accepted writes are logged.
    always @(negedge clk) begin
        if (mem_write && !mem_ack && !(hold_ack && mem_addr == hold_addr)) begin
            mem_ack = 1'b1;
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_data);
        end else begin
            mem_ack = 1'b0;
        end
        if (dma_end) end_hi++;
        if (dma_end && !end_prev) end_pulses++;
        end_prev = dma_end;
    end

    task automatic pulse_cmd(input logic [15:0] a);
        @(negedge clk); cmd = 1'b1; cmd_addr = a;
        @(negedge clk); cmd = 1'b0;
    endtask

    task automatic grant_after(input int n);
        bit got = 0;
        for (int c = 0; c < 50 && !got; c++) begin
            if (br) got = 1; else @(negedge clk);
        end
        total++;
        if (!got) begin bad++; $display("FAIL br_timeout got br=%b want 1", br); end
        repeat (n) @(negedge clk);
        bg = 1'b1;
    endtask

    task automatic wait_end();
        int e0 = end_pulses;
        bit got = 0;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            if (!br) bg = 1'b0;
            if (end_pulses > e0) got = 1;
        end
        total++;
        if (!got) begin bad++; $display("FAIL dma_end_timeout got none want pulse"); end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; cmd = 1'b0; cmd_addr = 16'h0; bg = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({br, mem_write, dma_end, busy} !== 4'b0000) begin
            bad++; $display("FAIL reset_ctrl got %b want 0000", {br, mem_write, dma_end, busy});
        end
        total++;
        if (offset !== 2'b11) begin bad++; $display("FAIL reset_offset got %b want 11", offset); end
        total++;
        if (mem_addr !== 16'h0 || mem_data !== 64'h0) begin
            bad++; $display("FAIL reset_mem got %h/%h want 0/0", mem_addr, mem_data);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int s = log_addr.size();
        int e0 = end_pulses;
        int h0 = end_hi;
        pulse_cmd(16'h01F4);
        total++;
        if (busy !== 1'b1 || br !== 1'b1) begin
            bad++; $display("FAIL basic_busy got busy=%b br=%b want 1/1", busy, br);
        end
        grant_after(2);
        wait_end();
        repeat (3) @(negedge clk);
        total++;
        if (log_addr.size() - s !== 3) begin
            bad++; $display("FAIL basic_count got %0d want 3", log_addr.size() - s);
        end else begin
            for (int k = 0; k < 3; k++) begin
                total++;
                if (log_addr[s+k] !== 16'h01F4 + 16'(4*k) || log_data[s+k] !== lpat[k]) begin
                    bad++; $display("FAIL basic_line%0d got %h/%h want %h/%h", k,
                        log_addr[s+k], log_data[s+k], 16'h01F4 + 16'(4*k), lpat[k]);
                end
            end
        end
        total++;
        if (end_pulses - e0 !== 1 || end_hi - h0 !== 1) begin
            bad++; $display("FAIL basic_end got pulses=%0d cycles=%0d want 1/1",
                end_pulses - e0, end_hi - h0);
        end
        total++;
        if (br !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL basic_idle got br=%b busy=%b want 0/0", br, busy);
        end
    endtask

    task automatic test_grant_stall();
        int s = log_addr.size();
        int viol = 0;
        pulse_cmd(16'h0040);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (br !== 1'b1 || mem_write !== 1'b0 || offset !== 2'b11) viol++;
        end
        total++;
        if (viol !== 0) begin bad++; $display("FAIL stall_hold got %0d bad cycles want 0", viol); end
        grant_after(0);
        wait_end();
        repeat (2) @(negedge clk);
        total++;
        if (log_addr.size() - s !== 3 || log_addr[s] !== 16'h0040) begin
            bad++; $display("FAIL stall_writes got n=%0d first=%h want 3/0040",
                log_addr.size() - s, log_addr[s]);
        end
    endtask

    task automatic test_bus_loss();
        int s = log_addr.size();
        int e0 = end_pulses;
        bit got = 0;
        hold_ack = 1'b1; hold_addr = 16'h0104;
        pulse_cmd(16'h0100);
        grant_after(1);
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (mem_write && mem_addr == 16'h0104) got = 1;
        end
        total++;
        if (!got) begin bad++; $display("FAIL loss_reach got no line1 write want one"); end
        bg = 1'b0;
        @(negedge clk);
        total++;
        if (mem_write !== 1'b0 || br !== 1'b1 || offset !== 2'b11) begin
            bad++; $display("FAIL loss_drop got wr=%b br=%b off=%b want 0/1/11",
                mem_write, br, offset);
        end
        repeat (2) @(negedge clk);
        hold_ack = 1'b0;
        bg = 1'b1;
        wait_end();
        repeat (3) @(negedge clk);
        total++;
        if (log_addr.size() - s !== 3) begin
            bad++; $display("FAIL loss_count got %0d want 3", log_addr.size() - s);
        end else begin
            for (int k = 0; k < 3; k++) begin
                total++;
                if (log_addr[s+k] !== 16'h0100 + 16'(4*k) || log_data[s+k] !== lpat[k]) begin
                    bad++; $display("FAIL loss_line%0d got %h/%h want %h/%h", k,
                        log_addr[s+k], log_data[s+k], 16'h0100 + 16'(4*k), lpat[k]);
                end
            end
        end
        total++;
        if (end_pulses - e0 !== 1) begin
            bad++; $display("FAIL loss_end got %0d want 1", end_pulses - e0);
        end
    endtask

    task automatic test_wrap();
        int s = log_addr.size();
        logic [15:0] exp_a [3];
        exp_a[0] = 16'hFFFC; exp_a[1] = 16'h0000; exp_a[2] = 16'h0004;
        pulse_cmd(16'hFFFC);
        grant_after(1);
        wait_end();
        repeat (2) @(negedge clk);
        total++;
        if (log_addr.size() - s !== 3) begin
            bad++; $display("FAIL wrap_count got %0d want 3", log_addr.size() - s);
        end else begin
            for (int k = 0; k < 3; k++) begin
                total++;
                if (log_addr[s+k] !== exp_a[k]) begin
                    bad++; $display("FAIL wrap_addr%0d got %h want %h", k, log_addr[s+k], exp_a[k]);
                end
            end
        end
    endtask

    task automatic test_ignored_cmd();
        int s = log_addr.size();
        int e0 = end_pulses;
        bit got = 0;
        pulse_cmd(16'h0300);
        grant_after(1);
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (mem_write) got = 1;
        end
        cmd = 1'b1; cmd_addr = 16'h4000;
        @(negedge clk); cmd = 1'b0;
        wait_end();
        repeat (4) @(negedge clk);
        total++;
        if (log_addr.size() - s !== 3) begin
            bad++; $display("FAIL ign_count got %0d want 3", log_addr.size() - s);
        end else begin
            total++;
            if (log_addr[s] !== 16'h0300 || log_addr[s+1] !== 16'h0304 || log_addr[s+2] !== 16'h0308) begin
                bad++; $display("FAIL ign_addrs got %h %h %h want 0300 0304 0308",
                    log_addr[s], log_addr[s+1], log_addr[s+2]);
            end
        end
        total++;
        if (end_pulses - e0 !== 1 || busy !== 1'b0) begin
            bad++; $display("FAIL ign_end got pulses=%0d busy=%b want 1/0", end_pulses - e0, busy);
        end
    endtask

    task automatic test_reset_midop();
        int e0 = end_pulses;
        int s;
        bit got = 0;
        pulse_cmd(16'h0500);
        grant_after(1);
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (offset == 2'd1 && !mem_write && br) got = 1;
        end
        total++;
        if (!got) begin bad++; $display("FAIL rst_reach got no line1 setup want one"); end
        reset_n = 1'b0;
        #1;
        total++;
        if (br !== 1'b0 || mem_write !== 1'b0 || offset !== 2'b11 || busy !== 1'b0) begin
            bad++; $display("FAIL rst_async got br=%b wr=%b off=%b busy=%b want 0/0/11/0",
                br, mem_write, offset, busy);
        end
        bg = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        total++;
        if (end_pulses - e0 !== 0) begin
            bad++; $display("FAIL rst_noend got %0d want 0", end_pulses - e0);
        end
        s = log_addr.size();
        pulse_cmd(16'h0600);
        grant_after(2);
        wait_end();
        repeat (2) @(negedge clk);
        total++;
        if (log_addr.size() - s !== 3 || log_addr[s] !== 16'h0600 || log_data[s] !== L0) begin
            bad++; $display("FAIL rst_restart got n=%0d first=%h/%h want 3/0600/%h",
                log_addr.size() - s, log_addr[s], log_data[s], L0);
        end
    endtask

    initial begin
        lpat[0] = L0; lpat[1] = L1; lpat[2] = L2;
        test_reset();
        test_basic();
        test_grant_stall();
        test_bus_loss();
        test_wrap();
        test_ignored_cmd();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
